mem_access_sequencer: RTL and testbench

Owns the processor's external memory port and pause control. A host-side loader, such as a serial receiver or a bench, issues single-word commands: WRITE, READ, RUN and HALT. The block halts the processor, waits for it to settle, performs the memory access with correct mode and hold timing, and returns read data through a valid/ready response channel. It sits between the loader and the Processor top, and replaces hand-timed pause/externalMemoryControl sequencing.

---
 rtl/mem_access_sequencer_pkg.sv | 27 ++
 rtl/memory_modes_pkg.sv | 13 +
 rtl/mem_seq_wait_counter.sv | 37 +++
 rtl/mem_access_sequencer.sv | 268 ++++++++++++++++++++++++++
 tb/tb_mem_access_sequencer.sv | 275 +++++++++++++++++++++++++++
 5 files changed

// File: rtl/mem_access_sequencer_pkg.sv
// Command opcodes, sequencer states and counter width for mem_access_sequencer.
package mem_access_sequencer_pkg;
   import memory_modes_pkg::*;

   localparam int unsigned MEM_SEQ_CNT_W = 8;

   typedef enum logic [1:0] {
      OpWrite = 2'd0,
      OpRead  = 2'd1,
      OpRun   = 2'd2,
      OpHalt  = 2'd3
   } mem_seq_op_e;

   typedef enum logic [2:0] {
      StHalted = 3'd0,
      StRun    = 3'd1,
      StSettle = 3'd2,
      StWrite  = 3'd3,
      StRead   = 3'd4,
      StResp   = 3'd5
   } mem_seq_state_e;

   function automatic logic mode_is_none(input logic [2:0] mode);
      return mode == RwNone;
   endfunction

endpackage

// File: rtl/memory_modes_pkg.sv
// Read/write mode encodings shared by the processor memory interface and its loaders.
package memory_modes_pkg;

   typedef enum logic [2:0] {
      RwByte             = 3'd0,
      RwHalfWord         = 3'd1,
      RwWord             = 3'd2,
      RwByteUnsigned     = 3'd3,
      RwHalfWordUnsigned = 3'd4,
      RwNone             = 3'd7
   } rw_mode_e;

endpackage

// File: rtl/mem_seq_wait_counter.sv
// Loadable down-counter shared by the settle, write-hold and read-latency waits.
module mem_seq_wait_counter
   import mem_access_sequencer_pkg::*;
#(
   parameter int unsigned Width = MEM_SEQ_CNT_W
) (
   input  logic             clk_i,
   input  logic             rst_ni,
   input  logic             load_i,
   input  logic [Width-1:0] load_val_i,
   output logic             done_o,
   output logic             last_o
);

   logic [Width-1:0] cnt_q, cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load_i) begin
         cnt_d = load_val_i;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - 1'b1;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign done_o = (cnt_q == '0);
   assign last_o = (cnt_q == Width'(1));

endmodule

// File: rtl/mem_access_sequencer.sv
// Sequences loader commands onto the processor memory port with pause/settle handling.
// Optional MEM_SEQ_CHECKSUM_EN adds a running sum of performed write data.
module mem_access_sequencer
   import memory_modes_pkg::*;
   import mem_access_sequencer_pkg::*;
#(
   parameter int unsigned PAUSE_SETTLE = 4,
   parameter int unsigned WRITE_HOLD   = 1,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic        clk_i,
   input  logic        rst_ni,
   input  logic        cmd_valid_i,
   output logic        cmd_ready_o,
   input  logic [1:0]  cmd_op_i,
   input  logic [31:0] cmd_addr_i,
   input  logic [31:0] cmd_data_i,
   input  logic [2:0]  cmd_mode_i,
   output logic        rsp_valid_o,
   input  logic        rsp_ready_i,
   output logic [31:0] rsp_data_o,
   output logic        pause_o,
   output logic        externalMemoryControl_o,
   output logic [31:0] externalAddress_o,
   output logic [31:0] externalData_o,
   output logic [2:0]  externalReadMode_o,
   output logic [2:0]  externalWriteMode_o,
   input  logic [31:0] externalDataOut_i,
   output logic        running_o
`ifdef MEM_SEQ_CHECKSUM_EN
   ,
   output logic [31:0] checksum_o
`endif
);

   localparam int unsigned CntW = MEM_SEQ_CNT_W;
   localparam logic [CntW-1:0] SettleLoad = CntW'(PAUSE_SETTLE - 1);
   localparam logic [CntW-1:0] HoldLoad   = CntW'(WRITE_HOLD);
   localparam logic [CntW-1:0] LatLoad    = CntW'(READ_LATENCY);

   mem_seq_state_e state_q, state_d;
   logic           pause_q, pause_d;
   logic           emc_q, emc_d;
   logic [31:0]    addr_q, addr_d;
   logic [31:0]    wdata_q, wdata_d;
   logic [2:0]     rmode_q, rmode_d;
   logic [2:0]     wmode_q, wmode_d;
   logic           rsp_valid_q, rsp_valid_d;
   logic [31:0]    rsp_data_q, rsp_data_d;

   mem_seq_op_e    op_q;
   logic [31:0]    cmd_addr_q;
   logic [31:0]    cmd_data_q;
   logic [2:0]     cmd_mode_q;

   mem_seq_op_e    cmd_op;
   logic           cmd_fire;
   logic           start;
   mem_seq_op_e    st_op;
   logic [31:0]    st_addr;
   logic [31:0]    st_data;
   logic [2:0]     st_mode;

   logic            cnt_load;
   logic [CntW-1:0] cnt_load_val;
   logic            cnt_done;
   logic            cnt_last;

`ifdef MEM_SEQ_CHECKSUM_EN
   logic [31:0] checksum_q, checksum_d;
`endif

   assign cmd_op      = mem_seq_op_e'(cmd_op_i);
   assign cmd_ready_o = (state_q == StHalted) || (state_q == StRun);
   assign running_o   = (state_q == StRun);
   assign cmd_fire    = cmd_valid_i && cmd_ready_o;

   // Only SETTLE launches from the latched copy; HALTED launches straight off the inputs.
   assign st_op   = (state_q == StSettle) ? op_q       : cmd_op;
   assign st_addr = (state_q == StSettle) ? cmd_addr_q : cmd_addr_i;
   assign st_data = (state_q == StSettle) ? cmd_data_q : cmd_data_i;
   assign st_mode = (state_q == StSettle) ? cmd_mode_q : cmd_mode_i;

   mem_seq_wait_counter #(
      .Width (CntW)
   ) u_wait_counter (
      .clk_i      (clk_i),
      .rst_ni     (rst_ni),
      .load_i     (cnt_load),
      .load_val_i (cnt_load_val),
      .done_o     (cnt_done),
      .last_o     (cnt_last)
   );

   always_comb begin
      state_d      = state_q;
      pause_d      = pause_q;
      emc_d        = emc_q;
      addr_d       = addr_q;
      wdata_d      = wdata_q;
      rmode_d      = rmode_q;
      wmode_d      = wmode_q;
      rsp_valid_d  = rsp_valid_q;
      rsp_data_d   = rsp_data_q;
      cnt_load     = 1'b0;
      cnt_load_val = '0;
      start        = 1'b0;
`ifdef MEM_SEQ_CHECKSUM_EN
      checksum_d   = checksum_q;
`endif

      unique case (state_q)
         StHalted: begin
            if (cmd_fire) begin
               unique case (cmd_op)
                  OpWrite, OpRead: start = 1'b1;
                  OpRun: begin
                     state_d = StRun;
                     pause_d = 1'b0;
                     emc_d   = 1'b0;
                  end
                  OpHalt: begin
`ifdef MEM_SEQ_CHECKSUM_EN
                     checksum_d = '0;
`endif
                  end
               endcase
            end
         end
         StRun: begin
            if (cmd_fire && cmd_op != OpRun) begin
               state_d      = StSettle;
               pause_d      = 1'b1;
               cnt_load     = 1'b1;
               cnt_load_val = SettleLoad;
            end
         end
         StSettle: begin
            if (cnt_done) begin
               emc_d = 1'b1;
               start = 1'b1;
            end
         end
         StWrite: begin
            if (cnt_last) begin
               wmode_d = RwNone;
               rmode_d = RwNone;
            end
            if (cnt_done) begin
               state_d = StHalted;
            end
         end
         StRead: begin
            if (cnt_done) begin
               rsp_data_d  = externalDataOut_i;
               rsp_valid_d = 1'b1;
               rmode_d     = RwNone;
               wmode_d     = RwNone;
               state_d     = StResp;
            end
         end
         StResp: begin
            if (rsp_ready_i) begin
               rsp_valid_d = 1'b0;
               state_d     = StHalted;
            end
         end
         default: state_d = StHalted;
      endcase

      // HALT from RUN arrives here with nothing to perform and simply parks in HALTED.
      if (start) begin
         unique case (st_op)
            OpWrite: begin
               if (mode_is_none(st_mode)) begin
                  state_d = StHalted;
               end else begin
                  state_d      = StWrite;
                  addr_d       = st_addr;
                  wdata_d      = st_data;
                  wmode_d      = st_mode;
                  rmode_d      = RwNone;
                  cnt_load     = 1'b1;
                  cnt_load_val = HoldLoad;
`ifdef MEM_SEQ_CHECKSUM_EN
                  checksum_d   = checksum_q + st_data;
`endif
               end
            end
            OpRead: begin
               if (mode_is_none(st_mode)) begin
                  state_d     = StResp;
                  rsp_valid_d = 1'b1;
                  rsp_data_d  = '0;
               end else begin
                  state_d      = StRead;
                  addr_d       = st_addr;
                  rmode_d      = st_mode;
                  wmode_d      = RwNone;
                  cnt_load     = 1'b1;
                  cnt_load_val = LatLoad;
               end
            end
            default: state_d = StHalted;
         endcase
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state_q     <= StHalted;
         pause_q     <= 1'b1;
         emc_q       <= 1'b1;
         addr_q      <= '0;
         wdata_q     <= '0;
         rmode_q     <= RwNone;
         wmode_q     <= RwNone;
         rsp_valid_q <= 1'b0;
         rsp_data_q  <= '0;
      end else begin
         state_q     <= state_d;
         pause_q     <= pause_d;
         emc_q       <= emc_d;
         addr_q      <= addr_d;
         wdata_q     <= wdata_d;
         rmode_q     <= rmode_d;
         wmode_q     <= wmode_d;
         rsp_valid_q <= rsp_valid_d;
         rsp_data_q  <= rsp_data_d;
      end
   end

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         op_q       <= OpHalt;
         cmd_addr_q <= '0;
         cmd_data_q <= '0;
         cmd_mode_q <= RwNone;
      end else if (cmd_fire) begin
         op_q       <= cmd_op;
         cmd_addr_q <= cmd_addr_i;
         cmd_data_q <= cmd_data_i;
         cmd_mode_q <= cmd_mode_i;
      end
   end

`ifdef MEM_SEQ_CHECKSUM_EN
   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         checksum_q <= '0;
      end else begin
         checksum_q <= checksum_d;
      end
   end

   assign checksum_o = checksum_q;
`endif

   assign pause_o                 = pause_q;
   assign externalMemoryControl_o = emc_q;
   assign externalAddress_o       = addr_q;
   assign externalData_o          = wdata_q;
   assign externalReadMode_o      = rmode_q;
   assign externalWriteMode_o     = wmode_q;
   assign rsp_valid_o             = rsp_valid_q;
   assign rsp_data_o              = rsp_data_q;

endmodule

// File: tb/tb_mem_access_sequencer.sv
// Scoreboard bench for mem_access_sequencer; covers MEM_SEQ_CHECKSUM_EN when defined.
module tb_mem_access_sequencer;
   import memory_modes_pkg::*;
   import mem_access_sequencer_pkg::*;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        cmd_valid = 1'b0;
   logic        cmd_ready;
   logic [1:0]  cmd_op = 2'd0;
   logic [31:0] cmd_addr = '0;
   logic [31:0] cmd_data = '0;
   logic [2:0]  cmd_mode = 3'd7;
   logic        rsp_valid;
   logic        rsp_ready = 1'b0;
   logic [31:0] rsp_data;
   logic        pause;
   logic        emc;
   logic [31:0] ext_addr;
   logic [31:0] ext_wdata;
   logic [2:0]  ext_rmode;
   logic [2:0]  ext_wmode;
   logic [31:0] ext_dout = '0;
   logic        running;
`ifdef MEM_SEQ_CHECKSUM_EN
   logic [31:0] checksum;
`endif

   always #5 clk = ~clk;

   mem_access_sequencer dut (
      .clk_i                   (clk),
      .rst_ni                  (rst_n),
      .cmd_valid_i             (cmd_valid),
      .cmd_ready_o             (cmd_ready),
      .cmd_op_i                (cmd_op),
      .cmd_addr_i              (cmd_addr),
      .cmd_data_i              (cmd_data),
      .cmd_mode_i              (cmd_mode),
      .rsp_valid_o             (rsp_valid),
      .rsp_ready_i             (rsp_ready),
      .rsp_data_o              (rsp_data),
      .pause_o                 (pause),
      .externalMemoryControl_o (emc),
      .externalAddress_o       (ext_addr),
      .externalData_o          (ext_wdata),
      .externalReadMode_o      (ext_rmode),
      .externalWriteMode_o     (ext_wmode),
      .externalDataOut_i       (ext_dout),
      .running_o               (running)
`ifdef MEM_SEQ_CHECKSUM_EN
      ,
      .checksum_o              (checksum)
`endif
   );

   // Synchronous one-cycle memory: data for the address presented this cycle appears next cycle.
   logic [31:0] mem [0:255];
   always @(posedge clk) begin
      if (ext_wmode != RwNone) mem[ext_addr[9:2]] <= ext_wdata;
      ext_dout <= (ext_rmode != RwNone) ? mem[ext_addr[9:2]] : 32'h0;
   end

   typedef struct packed {
      logic [31:0] addr;
      logic [31:0] data;
      logic [2:0]  mode;
   } wr_t;

   wr_t         exp_wr[$];
   logic [31:0] exp_rsp[$];
   int          checks = 0;
   int          errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h expected=%h", name, act, exp);
      end
   endtask

   // Write monitor: every cycle with a live write mode must match the next expected write.
   always @(negedge clk) begin
      if (rst_n && ext_wmode != RwNone) begin
         if (exp_wr.size() == 0) begin
            chk("unexpected_write_mode", {29'b0, ext_wmode}, {29'b0, RwNone});
         end else begin
            wr_t w;
            w = exp_wr.pop_front();
            chk("wr_addr", ext_addr, w.addr);
            chk("wr_data", ext_wdata, w.data);
            chk("wr_mode", {29'b0, ext_wmode}, {29'b0, w.mode});
            chk("wr_pause_emc", {30'b0, pause, emc}, 32'd3);
         end
      end
   end

   // Response monitor: pops on each cycle that the valid/ready handshake is presented.
   always @(negedge clk) begin
      if (rst_n && rsp_valid && rsp_ready) begin
         if (exp_rsp.size() == 0) begin
            chk("unexpected_rsp", {31'b0, rsp_valid}, 32'd0);
         end else begin
            chk("rsp_data", rsp_data, exp_rsp.pop_front());
         end
      end
   end

   task automatic send(input logic [1:0] op, input logic [31:0] a, input logic [31:0] d,
                       input logic [2:0] m);
      int n;
      n = 0;
      @(negedge clk);
      cmd_valid = 1'b1;
      cmd_op    = op;
      cmd_addr  = a;
      cmd_data  = d;
      cmd_mode  = m;
      while (!cmd_ready && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (!cmd_ready) chk("send_timeout", {31'b0, cmd_ready}, 32'd1);
      @(posedge clk);
      #1 cmd_valid = 1'b0;
   endtask

   task automatic wait_idle();
      int n;
      n = 0;
      @(negedge clk);
      while (!(cmd_ready && !rsp_valid) && n < 50) begin
         @(negedge clk);
         n++;
      end
      if (n >= 50) chk("idle_timeout", {31'b0, cmd_ready}, 32'd1);
   endtask

   initial begin
      int n;
      logic seen;
      for (int i = 0; i < 256; i++) mem[i] = 32'h0;
      mem[8'h88] = 32'h1234_5678;  // byte address 0x4E20

      // Reset values
      #2 rst_n = 1'b0;
      #10;
      chk("rst_pause", {31'b0, pause}, 32'd1);
      chk("rst_emc", {31'b0, emc}, 32'd1);
      chk("rst_rmode", {29'b0, ext_rmode}, {29'b0, RwNone});
      chk("rst_wmode", {29'b0, ext_wmode}, {29'b0, RwNone});
      chk("rst_addr", ext_addr, 32'h0);
      chk("rst_rsp_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rst_running", {31'b0, running}, 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      chk("rst_cmd_ready", {31'b0, cmd_ready}, 32'd1);

      // Write from HALTED
      exp_wr.push_back('{addr: 32'h400, data: 32'hDEAD_BEEF, mode: RwWord});
      send(OpWrite, 32'h400, 32'hDEAD_BEEF, RwWord);
      @(negedge clk);
      chk("wr1_wmode", {29'b0, ext_wmode}, {29'b0, RwWord});
      chk("wr1_rmode", {29'b0, ext_rmode}, {29'b0, RwNone});
      chk("wr1_ready0", {31'b0, cmd_ready}, 32'd0);
      @(negedge clk);
      chk("wr2_wmode_none", {29'b0, ext_wmode}, {29'b0, RwNone});
      chk("wr2_ready0", {31'b0, cmd_ready}, 32'd0);
      @(negedge clk);
      chk("wr3_ready1", {31'b0, cmd_ready}, 32'd1);

      // Read from HALTED with a stalled consumer
      rsp_ready = 1'b0;
      exp_rsp.push_back(32'h1234_5678);
      send(OpRead, 32'h4E20, 32'h0, RwWord);
      @(negedge clk);
      chk("rd_c1_valid", {31'b0, rsp_valid}, 32'd0);
      chk("rd_c1_rmode", {29'b0, ext_rmode}, {29'b0, RwWord});
      chk("rd_c1_addr", ext_addr, 32'h4E20);
      @(negedge clk);
      chk("rd_c2_valid", {31'b0, rsp_valid}, 32'd0);
      @(negedge clk);
      chk("rd_c3_valid", {31'b0, rsp_valid}, 32'd1);
      chk("rd_c3_rmode_none", {29'b0, ext_rmode}, {29'b0, RwNone});
      for (int i = 0; i < 4; i++) begin
         @(negedge clk);
         chk("rd_hold_valid", {31'b0, rsp_valid}, 32'd1);
         chk("rd_hold_data", rsp_data, 32'h1234_5678);
      end
      @(posedge clk);
      #1 rsp_ready = 1'b1;
      wait_idle();
      chk("rd_done_valid", {31'b0, rsp_valid}, 32'd0);

      // RUN, then READ through the settle window
      send(OpRun, 32'h0, 32'h0, RwNone);
      @(negedge clk);
      chk("run_pause", {31'b0, pause}, 32'd0);
      chk("run_emc", {31'b0, emc}, 32'd0);
      chk("run_running", {31'b0, running}, 32'd1);
      exp_rsp.push_back(32'h1234_5678);
      send(OpRead, 32'h4E20, 32'h0, RwWord);
      n = 0;
      @(negedge clk);
      chk("settle_running", {31'b0, running}, 32'd0);
      while (pause && !emc && n < 20) begin
         n++;
         @(negedge clk);
      end
      chk("settle_cycles", 32'(n), 32'd4);
      wait_idle();
      chk("run_rd_pause", {31'b0, pause}, 32'd1);
      chk("run_rd_emc", {31'b0, emc}, 32'd1);
      chk("run_rd_running", {31'b0, running}, 32'd0);

      // Reset during a read wait
      rsp_ready = 1'b0;
      send(OpRead, 32'h4E20, 32'h0, RwWord);
      @(negedge clk);
      chk("mid_rd_rmode", {29'b0, ext_rmode}, {29'b0, RwWord});
      rst_n = 1'b0;
      #1;
      chk("mid_rst_pause", {31'b0, pause}, 32'd1);
      chk("mid_rst_emc", {31'b0, emc}, 32'd1);
      chk("mid_rst_rmode", {29'b0, ext_rmode}, {29'b0, RwNone});
      chk("mid_rst_addr", ext_addr, 32'h0);
      chk("mid_rst_valid", {31'b0, rsp_valid}, 32'd0);
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      seen = 1'b0;
      for (int i = 0; i < 6; i++) begin
         @(negedge clk);
         if (rsp_valid) seen = 1'b1;
      end
      chk("post_rst_no_rsp", {31'b0, seen}, 32'd0);
      exp_wr.push_back('{addr: 32'h8, data: 32'h0000_A5A5, mode: RwHalfWord});
      send(OpWrite, 32'h8, 32'h0000_A5A5, RwHalfWord);
      wait_idle();

      // NONE-mode accesses: no memory traffic, read answers zero
      rsp_ready = 1'b1;
      exp_rsp.push_back(32'h0);
      send(OpRead, 32'h4E20, 32'h0, RwNone);
      wait_idle();
      send(OpWrite, 32'h10, 32'h7, RwNone);
      wait_idle();

`ifdef MEM_SEQ_CHECKSUM_EN
      send(OpHalt, 32'h0, 32'h0, RwNone);
      @(negedge clk);
      chk("cks_clear0", checksum, 32'h0);
      exp_wr.push_back('{addr: 32'h20, data: 32'h1, mode: RwWord});
      send(OpWrite, 32'h20, 32'h1, RwWord);
      exp_wr.push_back('{addr: 32'h24, data: 32'hFFFF_FFFF, mode: RwWord});
      send(OpWrite, 32'h24, 32'hFFFF_FFFF, RwWord);
      exp_wr.push_back('{addr: 32'h28, data: 32'h5, mode: RwWord});
      send(OpWrite, 32'h28, 32'h5, RwWord);
      send(OpWrite, 32'h2C, 32'h7, RwNone);
      wait_idle();
      chk("cks_sum", checksum, 32'h5);
      send(OpHalt, 32'h0, 32'h0, RwNone);
      @(negedge clk);
      chk("cks_clear1", checksum, 32'h0);
`endif

      repeat (3) @(negedge clk);
      chk("wr_queue_empty", 32'(exp_wr.size()), 32'd0);
      chk("rsp_queue_empty", 32'(exp_rsp.size()), 32'd0);
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
